// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle control unit: instruction field
// encodings, ALU select codes, PC source codes, FSM states, trap causes and
// a small opcode classification helper.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type funct field values (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;

  // ALU select encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  // PC source encodings
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ILLEGAL     = 2'b01,
    CAUSE_BUS_TIMEOUT = 2'b10
  } trap_cause_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_J       = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  // Opcode-only classification; R-type funct legality is checked separately.
  function automatic instr_class_t classify_opcode(input logic [5:0] op);
    instr_class_t cls;
    case (op)
      OP_R:    cls = CLS_R;
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational R-type funct to ALU select mapping.
//   funct    in   FUNCT_W    captured R-type funct field
//   alu_sel  out  ALU_SEL_W  ALU operation (ADD when illegal)
//   illegal  out  1          funct not recognised, or MUL/DIV while disabled
// ---------------------------------------------------------------------------
module alu_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int FUNCT_W       = 6,
  parameter int ALU_SEL_W     = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 illegal
);

  logic [3:0] code;

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (6'(funct))
      FN_ADD: code = ALU_ADD;
      FN_SUB: code = ALU_SUB;
      FN_AND: code = ALU_AND;
      FN_OR:  code = ALU_OR;
      FN_MUL: begin
        code    = ALU_MUL;
        illegal = (ENABLE_MULDIV == 0);
      end
      FN_DIV: begin
        code    = ALU_DIV;
        illegal = (ENABLE_MULDIV == 0);
      end
      default: illegal = 1'b1;
    endcase
    // Never present a MUL/DIV select for an instruction that will trap.
    if (illegal) code = ALU_ADD;
  end

  assign alu_sel = ALU_SEL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle FSM controller: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Drives datapath enables one state at a time, handles memory wait states
// with a timeout, branch/jump PC control, illegal-instruction traps and a
// retired-instruction counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid         fetched instruction present on opcode/funct
//   opcode, funct       instruction fields, captured in FETCH
//   alu_zero            ALU zero flag (BEQ, EXEC only)
//   mem_ready           data memory completes access (MEM only)
//   ir_load, pc_write, pc_select, reg_write, alu_src, mem_read, mem_write,
//   mem_to_reg, alu_sel datapath controls
//   trap, trap_cause    sticky trap status
//   retired             completed instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int FUNCT_W       = 6,
  parameter int ALU_SEL_W     = 4,
  parameter int MEM_TIMEOUT   = 16,
  parameter int ENABLE_MULDIV = 1,
  parameter int RETIRE_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_select,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [RETIRE_W-1:0]  retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                state_reg, state_next;
  trap_cause_t           cause_reg, cause_next;
  logic [OPCODE_W-1:0]   opcode_reg;
  logic [FUNCT_W-1:0]    funct_reg;
  logic [WAIT_W-1:0]     wait_reg;
  logic [RETIRE_W-1:0]   retired_reg;
  logic                  retire;

  instr_class_t          cls;
  logic [ALU_SEL_W-1:0]  r_alu_sel;
  logic                  r_illegal;
  logic [ALU_SEL_W-1:0]  exec_alu_sel;
  logic                  exec_alu_src;

  alu_decoder #(
    .FUNCT_W       (FUNCT_W),
    .ALU_SEL_W     (ALU_SEL_W),
    .ENABLE_MULDIV (ENABLE_MULDIV)
  ) u_alu_decoder (
    .funct   (funct_reg),
    .alu_sel (r_alu_sel),
    .illegal (r_illegal)
  );

  // Classification and EXEC-phase ALU controls depend only on captured fields.
  always_comb begin
    cls = classify_opcode(6'(opcode_reg));
    if (cls == CLS_R && r_illegal) cls = CLS_ILLEGAL;

    exec_alu_sel = ALU_SEL_W'(ALU_ADD);
    if (cls == CLS_R)        exec_alu_sel = r_alu_sel;
    else if (cls == CLS_BEQ) exec_alu_sel = ALU_SEL_W'(ALU_SUB);

    exec_alu_src = (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    retire     = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_select  = PC_HOLD;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_sel    = ALU_SEL_W'(ALU_ADD);

    case (state_reg)
      FETCH: begin
        ir_load = instr_valid;
        if (instr_valid) state_next = DECODE;
      end

      DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_next = TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (cls == CLS_J) begin
          pc_write   = 1'b1;
          pc_select  = PC_JUMP;
          retire     = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end

      EXEC: begin
        alu_src = exec_alu_src;
        alu_sel = exec_alu_sel;
        if (cls == CLS_BEQ) begin
          pc_write   = 1'b1;
          pc_select  = alu_zero ? PC_BRANCH : PC_INC;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (cls == CLS_LW || cls == CLS_SW) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end

      MEM: begin
        mem_read  = (cls == CLS_LW);
        mem_write = (cls == CLS_SW);
        alu_sel   = ALU_SEL_W'(ALU_ADD);
        if (mem_ready) begin
          if (cls == CLS_LW) begin
            state_next = WB;
          end else begin
            pc_write   = 1'b1;
            pc_select  = PC_INC;
            retire     = 1'b1;
            state_next = FETCH;
          end
        end else if (wait_reg == WAIT_LAST) begin
          // Strobe is still high this cycle; TRAP drives none.
          state_next = TRAP;
          cause_next = CAUSE_BUS_TIMEOUT;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LW);
        if (cls == CLS_R || cls == CLS_ADDI) begin
          alu_src = exec_alu_src;
          alu_sel = exec_alu_sel;
        end
        pc_write   = 1'b1;
        pc_select  = PC_INC;
        retire     = 1'b1;
        state_next = FETCH;
      end

      TRAP: begin
        state_next = TRAP;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      cause_reg   <= CAUSE_NONE;
      opcode_reg  <= '0;
      funct_reg   <= '0;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (state_reg == FETCH && instr_valid) begin
        opcode_reg <= opcode;
        funct_reg  <= funct;
      end
      // Counts MEM cycles already spent; zero on the first MEM cycle.
      if (state_reg == MEM) wait_reg <= wait_reg + WAIT_W'(1);
      else                  wait_reg <= '0;
      if (retire) retired_reg <= retired_reg + RETIRE_W'(1);
    end
  end

  assign trap       = (state_reg == TRAP);
  assign trap_cause = cause_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Randomized self-checking bench. Expected per-cycle control vectors come
// from an instruction-level model (latency, strobe windows per instruction
// kind). A second instance with MUL/DIV disabled and a 4-bit retire counter
// covers the MUL/DIV-illegal case and counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int TIMEOUT = 16;
  // Vector layout: {ir_load, pc_write, pc_select[1:0], reg_write, alu_src,
  //                 mem_read, mem_write, mem_to_reg, alu_sel[3:0], trap, cause[1:0]}
  localparam logic [15:0] V_IDLE  = 16'h3000;
  localparam logic [15:0] V_FETCH = 16'hB000;
  localparam logic [15:0] V_ILL   = 16'h3005;
  localparam logic [15:0] V_BUS   = 16'h3006;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;

  logic ir_load_a, pc_write_a, reg_write_a, alu_src_a, mem_read_a, mem_write_a, mem_to_reg_a, trap_a;
  logic [1:0] pc_select_a, trap_cause_a;
  logic [3:0] alu_sel_a;
  logic [31:0] retired_a;
  logic ir_load_b, pc_write_b, reg_write_b, alu_src_b, mem_read_b, mem_write_b, mem_to_reg_b, trap_b;
  logic [1:0] pc_select_b, trap_cause_b;
  logic [3:0] alu_sel_b;
  logic [3:0] retired_b;
  logic [15:0] obs_a, obs_b;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;
  int exp_ret_b = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .ir_load(ir_load_a), .pc_write(pc_write_a),
    .pc_select(pc_select_a), .reg_write(reg_write_a), .alu_src(alu_src_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_to_reg(mem_to_reg_a), .alu_sel(alu_sel_a), .trap(trap_a),
    .trap_cause(trap_cause_a), .retired(retired_a)
  );

  multicycle_control_unit #(.ENABLE_MULDIV(0), .RETIRE_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .ir_load(ir_load_b), .pc_write(pc_write_b),
    .pc_select(pc_select_b), .reg_write(reg_write_b), .alu_src(alu_src_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b), .alu_sel(alu_sel_b), .trap(trap_b),
    .trap_cause(trap_cause_b), .retired(retired_b)
  );

  assign obs_a = {ir_load_a, pc_write_a, pc_select_a, reg_write_a, alu_src_a, mem_read_a,
                  mem_write_a, mem_to_reg_a, alu_sel_a, trap_a, trap_cause_a};
  assign obs_b = {ir_load_b, pc_write_b, pc_select_b, reg_write_b, alu_src_b, mem_read_b,
                  mem_write_b, mem_to_reg_b, alu_sel_b, trap_b, trap_cause_b};

  // ---------------- reference model ----------------
  // kind: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, -1 illegal opcode
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      OP_R:    return 0;
      OP_ADDI: return 1;
      OP_LW:   return 2;
      OP_SW:   return 3;
      OP_BEQ:  return 4;
      OP_J:    return 5;
      default: return -1;
    endcase
  endfunction

  // Total cycles from FETCH to completion; d = extra MEM wait cycles.
  function automatic int latency(input int kd, input int d);
    case (kd)
      5:       return 2;
      4:       return 3;
      3:       return 4 + d;
      2:       return 5 + d;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] r_code(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'd0;
      6'h22:   return 4'd1;
      6'h18:   return 4'd2;
      6'h1a:   return 4'd3;
      6'h24:   return 4'd4;
      6'h25:   return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] model_vec(input logic [5:0] op, input logic [5:0] fn,
                                            input int k, input int d, input logic zero);
    int kd;
    int n;
    logic last, in_mem, asrc;
    logic [1:0] ps;
    logic [3:0] asel;
    kd = kind_of(op);
    n = latency(kd, d);
    last = (k == n - 1);
    in_mem = (kd == 2 || kd == 3) && k >= 3 && k <= 3 + d;
    ps = 2'b11;
    if (last) ps = (kd == 5) ? 2'b10 : ((kd == 4 && zero) ? 2'b01 : 2'b00);
    asel = 4'd0;
    if (kd == 0 && (k == 2 || k == 3)) asel = r_code(fn);
    if (kd == 4 && k == 2) asel = 4'd1;
    asrc = (k == 2 && (kd == 1 || kd == 2 || kd == 3)) || (k == 3 && kd == 1);
    return {(k == 0), last, ps, (last && kd <= 2), asrc, (in_mem && kd == 2),
            (in_mem && kd == 3), (last && kd == 2), asel, 1'b0, 2'b00};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = 0;
    exp_ret_b = 0;
  endtask

  // Starts just after a rising edge with both DUTs in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int d,
                           input logic zero, input int pre, input bit chk_b, input string name);
    int n;
    logic in_mem;
    logic [15:0] exp;
    for (int p = 0; p < pre; p++) begin
      instr_valid = 1'b0;
      opcode = 6'($urandom);
      funct = 6'($urandom);
      mem_ready = 1'($urandom);
      @(negedge clk);
      tests++;
      if (obs_a !== V_IDLE) begin
        fails++;
        $display("FAIL %s idle%0d: got %h expected %h", name, p, obs_a, V_IDLE);
      end
      @(posedge clk);
      #1;
    end
    n = latency(kind_of(op), d);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        instr_valid = 1'b1;
        opcode = op;
        funct = fn;
      end else begin
        instr_valid = 1'($urandom);
        opcode = 6'($urandom);
        funct = 6'($urandom);
      end
      in_mem = (op == OP_LW || op == OP_SW) && k >= 3;
      mem_ready = in_mem ? (k == 3 + d) : 1'($urandom);
      alu_zero = (k == 2) ? zero : 1'($urandom);
      @(negedge clk);
      tests++;
      exp = model_vec(op, fn, k, d, zero);
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL %s cyc%0d: got %h expected %h", name, k, obs_a, exp);
      end
      @(posedge clk);
      #1;
    end
    exp_ret++;
    tests++;
    if (retired_a !== 32'(exp_ret)) begin
      fails++;
      $display("FAIL %s retired: got %0d expected %0d", name, retired_a, exp_ret);
    end
    if (chk_b) begin
      exp_ret_b++;
      tests++;
      if (retired_b !== 4'(exp_ret_b)) begin
        fails++;
        $display("FAIL %s retired_b: got %0d expected %0d", name, retired_b, exp_ret_b % 16);
      end
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    $display("[TB] %s op=%b funct=%b wait=%0d retired=%0d", name, op, fn, d, retired_a);
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input bit use_b,
                             input string name);
    logic [15:0] o;
    logic [15:0] exp;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        instr_valid = 1'b1;
        opcode = op;
        funct = fn;
      end else begin
        instr_valid = 1'($urandom);
        opcode = 6'($urandom);
        funct = 6'($urandom);
      end
      mem_ready = 1'($urandom);
      alu_zero = 1'($urandom);
      @(negedge clk);
      o = use_b ? obs_b : obs_a;
      exp = (k == 0) ? V_FETCH : ((k == 1) ? V_IDLE : V_ILL);
      tests++;
      if (o !== exp) begin
        fails++;
        $display("FAIL %s cyc%0d: got %h expected %h", name, k, o, exp);
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    $display("[TB] %s op=%b funct=%b trapped", name, op, fn);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if (obs_a !== V_IDLE || retired_a !== 32'd0) begin
      fails++;
      $display("FAIL reset_a: got %h/%0d expected %h/0", obs_a, retired_a, V_IDLE);
    end
    tests++;
    if (obs_b !== V_IDLE || retired_b !== 4'd0) begin
      fails++;
      $display("FAIL reset_b: got %h/%0d expected %h/0", obs_b, retired_b, V_IDLE);
    end
    do_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_r_add();
    do_reset();
    run_instr(OP_R, 6'h20, 0, 1'b0, 0, 1'b1, "r_add");
    run_instr(OP_ADDI, 6'($urandom), 0, 1'b0, 1, 1'b1, "addi");
  endtask

  task automatic test_lw_wait();
    do_reset();
    run_instr(OP_LW, 6'($urandom), 3, 1'b0, 0, 1'b1, "lw_wait3");
    run_instr(OP_SW, 6'($urandom), 0, 1'b0, 0, 1'b1, "sw_fast");
  endtask

  task automatic test_beq();
    do_reset();
    run_instr(OP_BEQ, 6'($urandom), 0, 1'b1, 0, 1'b1, "beq_taken");
    run_instr(OP_BEQ, 6'($urandom), 0, 1'b0, 0, 1'b1, "beq_not_taken");
  endtask

  task automatic test_illegal();
    do_reset();
    run_illegal(6'h3f, 6'($urandom), 1'b0, "bad_opcode");
    do_reset();
    run_illegal(OP_R, 6'h18, 1'b1, "mul_disabled");
    do_reset();
    run_illegal(OP_R, 6'h3f, 1'b0, "bad_funct");
    tests++;
    if (retired_a !== 32'd0) begin
      fails++;
      $display("FAIL illegal_retired: got %0d expected 0", retired_a);
    end
  endtask

  task automatic test_sw_timeout();
    logic [15:0] exp;
    logic [5:0] fn;
    do_reset();
    fn = 6'($urandom);
    for (int k = 0; k < 3 + TIMEOUT + 3; k++) begin
      if (k == 0) begin
        instr_valid = 1'b1;
        opcode = OP_SW;
        funct = fn;
      end else begin
        instr_valid = 1'($urandom);
        opcode = 6'($urandom);
      end
      mem_ready = (k < 3) ? 1'($urandom) : 1'b0;
      alu_zero = 1'($urandom);
      @(negedge clk);
      exp = (k < 3 + TIMEOUT) ? model_vec(OP_SW, fn, k, 1000, 1'b0) : V_BUS;
      tests++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL sw_timeout cyc%0d: got %h expected %h", k, obs_a, exp);
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    tests++;
    if (retired_a !== 32'd0) begin
      fails++;
      $display("FAIL sw_timeout_retired: got %0d expected 0", retired_a);
    end
    $display("[TB] sw_timeout trapped retired=%0d", retired_a);
  endtask

  task automatic test_jump_reset();
    logic [15:0] exp;
    do_reset();
    run_instr(OP_J, 6'($urandom), 0, 1'b0, 0, 1'b1, "j_first");
    run_instr(OP_J, 6'($urandom), 0, 1'b0, 0, 1'b1, "j_second");
    for (int k = 0; k < 4; k++) begin
      instr_valid = (k == 0);
      opcode = OP_LW;
      mem_ready = 1'b0;
      @(negedge clk);
      exp = model_vec(OP_LW, 6'h00, k, 5, 1'b0);
      tests++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL lw_pre_reset cyc%0d: got %h expected %h", k, obs_a, exp);
      end
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs_a !== V_IDLE || retired_a !== 32'd0) begin
      fails++;
      $display("FAIL mid_mem_reset: got %h/%0d expected %h/0", obs_a, retired_a, V_IDLE);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = 0;
    exp_ret_b = 0;
    mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (obs_a !== V_IDLE || retired_a !== 32'd0) begin
      fails++;
      $display("FAIL post_reset: got %h/%0d expected %h/0", obs_a, retired_a, V_IDLE);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    $display("[TB] reset during LW MEM abandoned access");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[6];
    logic [5:0] fns_safe[4];
    logic [5:0] fns_all[6];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    fns_safe = '{6'h20, 6'h22, 6'h24, 6'h25};
    fns_all = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h1a};
    do_reset();
    // 20 instructions legal on both instances: exercises the 4-bit wrap.
    for (int i = 0; i < 20; i++) begin
      op = ops[$urandom_range(0, 5)];
      fn = (op == OP_R) ? fns_safe[$urandom_range(0, 3)] : 6'($urandom);
      run_instr(op, fn, int'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(0, 1)),
                1'b1, "rand_both");
    end
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 5)];
      fn = (op == OP_R) ? fns_all[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(op, fn, int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 1)),
                1'b0, "rand_muldiv");
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_sw_timeout();
    test_jump_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
